// File: rtl/mips_load_store_unit.sv
// mips_load_store_unit
// Load/store unit between the EX/MEM stage and a word-wide data memory.
// Big-endian byte lanes (offset 0 = bits 31:24). Sub-word stores are done
// as read-modify-write because the memory only writes whole words.
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When it is defined,
// misaligned halfword/word accesses are rejected with resp_error. When it is
// undefined, the low address bits are cleared and the access proceeds.
module mips_load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        sig_mem_read,
    output logic        sig_mem_write,
    input  logic [31:0] mem_read_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    logic [1:0]  r_state;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_offset;
    logic [15:0] r_wdata;

    logic        w_accept;
    logic        w_misalign;
    logic [1:0]  w_off_eff;

    // Pick the addressed lane out of a memory word and extend it to 32 bits.
    function automatic logic [31:0] f_extract(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off,
                                              input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        if (off[1]) begin
            h = word[15:0];
        end else begin
            h = word[31:16];
        end
        case (size)
            SZ_BYTE: res = uns ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_HALF: res = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace the addressed lane(s) of a memory word with right-justified store data.
    function automatic logic [31:0] f_merge(input logic [31:0] word,
                                            input logic [1:0]  size,
                                            input logic [1:0]  off,
                                            input logic [15:0] wd);
        logic [31:0] res;
        res = word;
        case (size)
            SZ_BYTE: begin
                case (off)
                    2'd0:    res[31:24] = wd[7:0];
                    2'd1:    res[23:16] = wd[7:0];
                    2'd2:    res[15:8]  = wd[7:0];
                    default: res[7:0]   = wd[7:0];
                endcase
            end
            SZ_HALF: begin
                if (off[1]) begin
                    res[15:0] = wd;
                end else begin
                    res[31:16] = wd;
                end
            end
            default: res = word;
        endcase
        return res;
    endfunction

    assign req_ready = (r_state == S_IDLE) && !rst;

    // Decode the incoming request: acceptance, alignment check and effective lane offset.
    always_comb begin
        w_accept = req_valid && req_ready;
`ifdef LSU_MISALIGN_TRAP_EN
        w_misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                     ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
        w_off_eff  = req_addr[1:0];
`else
        w_misalign = 1'b0;
        case (req_size)
            SZ_HALF: w_off_eff = {req_addr[1], 1'b0};
            SZ_WORD: w_off_eff = 2'b00;
            default: w_off_eff = req_addr[1:0];
        endcase
`endif
    end

    // Sequence IDLE -> (READ) -> (WRITE) -> RESP and register every memory/response output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_write        <= 1'b0;
            r_size         <= 2'b00;
            r_unsigned     <= 1'b0;
            r_offset       <= 2'b00;
            r_wdata        <= 16'd0;
            resp_valid     <= 1'b0;
            resp_rdata     <= 32'd0;
            resp_error     <= 1'b0;
            mem_address    <= 32'd0;
            mem_write_data <= 32'd0;
            sig_mem_read   <= 1'b0;
            sig_mem_write  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_write    <= req_write;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_offset   <= w_off_eff;
                        r_wdata    <= req_wdata[15:0];
                        if ((req_size == SZ_RSVD) || w_misalign) begin
                            // Rejected: answer next cycle without touching memory.
                            r_state    <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else if (req_write && (req_size == SZ_WORD)) begin
                            r_state        <= S_WRITE;
                            mem_address    <= {req_addr[31:2], 2'b00};
                            mem_write_data <= req_wdata;
                            sig_mem_write  <= 1'b1;
                        end else begin
                            // Loads and sub-word stores both start with a read.
                            r_state      <= S_READ;
                            mem_address  <= {req_addr[31:2], 2'b00};
                            sig_mem_read <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_READ: begin
                    sig_mem_read <= 1'b0;
                    if (r_write) begin
                        r_state        <= S_WRITE;
                        mem_write_data <= f_merge(mem_read_data, r_size, r_offset, r_wdata);
                        sig_mem_write  <= 1'b1;
                    end else begin
                        r_state    <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b0;
                        resp_rdata <= f_extract(mem_read_data, r_size, r_offset, r_unsigned);
                    end
                end
                S_WRITE: begin
                    r_state       <= S_RESP;
                    sig_mem_write <= 1'b0;
                    resp_valid    <= 1'b1;
                    resp_error    <= 1'b0;
                    resp_rdata    <= 32'd0;
                end
                S_RESP: begin
                    r_state    <= S_IDLE;
                    resp_valid <= 1'b0;
                    resp_error <= 1'b0;
                end
                default: begin
                    r_state       <= S_IDLE;
                    sig_mem_read  <= 1'b0;
                    sig_mem_write <= 1'b0;
                    resp_valid    <= 1'b0;
                    resp_error    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_load_store_unit.sv
// Testbench for mips_load_store_unit: directed vector table, a mid-RMW reset
// sequence, and randomized requests checked against a behavioural model.
module tb_mips_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        sig_mem_read;
    logic        sig_mem_write;
    logic [31:0] mem_read_data;

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];

    int n_cmp;
    int n_err;

    mips_load_store_unit dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_error     (resp_error),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .sig_mem_read   (sig_mem_read),
        .sig_mem_write  (sig_mem_write),
        .mem_read_data  (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-wide memory: combinational read, write on the rising edge.
    assign mem_read_data = mem[mem_address[7:2]];
    always @(posedge clk) begin
        if (sig_mem_write) mem[mem_address[7:2]] <= mem_write_data;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Reference: access semantics from byte counts, shifts and masks.
    task automatic model(input bit w, input bit [1:0] sz, input bit u, input bit [31:0] a,
                         input bit [31:0] wd, output bit [31:0] rd, output bit er,
                         output int lat, output int rc, output int wc);
        int idx;
        int o;
        int nbytes;
        int shift;
        bit [31:0] word;
        bit [31:0] mask;
        bit [31:0] val;
        idx = int'(a[7:2]);
        o = int'(a[1:0]);
        word = ref_mem[idx];
        rd = 32'd0; er = 1'b0; rc = 0; wc = 0; lat = 1;
        if (sz == 2'd3) begin
            er = 1'b1;
            return;
        end
        nbytes = (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((o % nbytes) != 0) begin
            er = 1'b1;
            return;
        end
`else
        o = o - (o % nbytes);
`endif
        shift = 8 * (4 - o - nbytes);
        mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        if (!w) begin
            val = (word >> shift) & mask;
            if (!u && nbytes < 4 && val[8 * nbytes - 1]) val = val | ~mask;
            rd = val; rc = 1; lat = 2;
        end else begin
            ref_mem[idx] = (word & ~(mask << shift)) | ((wd & mask) << shift);
            if (nbytes == 4) begin
                wc = 1; lat = 2;
            end else begin
                rc = 1; wc = 2; lat = 3;
            end
        end
    endtask

    // Issue one request and check response value, latency and strobe cycles.
    task automatic do_req(input string nm, input bit w, input bit [1:0] sz, input bit u,
                          input bit [31:0] a, input bit [31:0] wd, input bit [31:0] e_rd,
                          input bit e_er, input int e_lat, input int e_rc, input int e_wc);
        int lat;
        int rc;
        int wc;
        bit [31:0] rd;
        bit er;
        bit both;
        bit addr_bad;
        lat = 0; rc = 0; wc = 0; rd = 32'd0; er = 1'b0; both = 1'b0; addr_bad = 1'b0;
        @(negedge clk);
        chk({nm, ":ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (sig_mem_read) begin
                rc = (rc == 0) ? k : 99;
                if (mem_address !== (a & 32'hFFFF_FFFC)) addr_bad = 1'b1;
            end
            if (sig_mem_write) begin
                wc = (wc == 0) ? k : 99;
                if (mem_address !== (a & 32'hFFFF_FFFC)) addr_bad = 1'b1;
            end
            if (sig_mem_read && sig_mem_write) both = 1'b1;
            if (resp_valid) begin
                lat = k; rd = resp_rdata; er = resp_error;
                break;
            end
        end
        chk({nm, ":latency"}, lat, e_lat);
        chk({nm, ":rdata"}, rd, e_rd);
        chk({nm, ":error"}, {31'd0, er}, {31'd0, e_er});
        chk({nm, ":read_cycle"}, rc, e_rc);
        chk({nm, ":write_cycle"}, wc, e_wc);
        chk({nm, ":strobe_clash_or_addr"}, {30'd0, both, addr_bad}, 32'd0);
    endtask

    typedef struct {
        string     nm;
        bit        w;
        bit [1:0]  sz;
        bit        u;
        bit [31:0] a;
        bit [31:0] wd;
        bit [31:0] e_rd;
        bit        e_er;
        int        e_lat;
        int        e_rc;
        int        e_wc;
    } vec_t;

    vec_t vecs[13];

    initial begin
        bit [31:0] m_rd;
        bit        m_er;
        int        m_lat;
        int        m_rc;
        int        m_wc;
        bit [31:0] saved;

        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[4] = 32'h8899_AABB;
        ref_mem[4] = 32'h8899_AABB;

        vecs[0]  = '{"lb_s_11",   1'b0, 2'd0, 1'b0, 32'h11, 32'h0,        32'hFFFF_FF99, 1'b0, 2, 1, 0};
        vecs[1]  = '{"lh_u_12",   1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        32'h0000_AABB, 1'b0, 2, 1, 0};
        vecs[2]  = '{"lh_s_10",   1'b0, 2'd1, 1'b0, 32'h10, 32'h0,        32'hFFFF_8899, 1'b0, 2, 1, 0};
        vecs[3]  = '{"sb_13",     1'b1, 2'd0, 1'b0, 32'h13, 32'h55,       32'h0,         1'b0, 3, 1, 2};
        vecs[4]  = '{"lw_10_a",   1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h8899_AA55, 1'b0, 2, 1, 0};
        vecs[5]  = '{"sw_10",     1'b1, 2'd2, 1'b0, 32'h10, 32'h1234_5678, 32'h0,        1'b0, 2, 0, 1};
        vecs[6]  = '{"lw_10_b",   1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h1234_5678, 1'b0, 2, 1, 0};
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[7]  = '{"lw_12_mis", 1'b0, 2'd2, 1'b0, 32'h12, 32'h0,        32'h0,         1'b1, 1, 0, 0};
`else
        vecs[7]  = '{"lw_12_mis", 1'b0, 2'd2, 1'b0, 32'h12, 32'h0,        32'h1234_5678, 1'b0, 2, 1, 0};
`endif
        vecs[8]  = '{"rsvd_size", 1'b0, 2'd3, 1'b0, 32'h10, 32'h0,        32'h0,         1'b1, 1, 0, 0};
        vecs[9]  = '{"lb_u_10",   1'b0, 2'd0, 1'b1, 32'h10, 32'h0,        32'h0000_0012, 1'b0, 2, 1, 0};
        vecs[10] = '{"sh_12",     1'b1, 2'd1, 1'b0, 32'h12, 32'hBEEF_CAFE, 32'h0,        1'b0, 3, 1, 2};
        vecs[11] = '{"lh_s_12",   1'b0, 2'd1, 1'b0, 32'h12, 32'h0,        32'hFFFF_CAFE, 1'b0, 2, 1, 0};
        vecs[12] = '{"lb_s_13",   1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        32'hFFFF_FFFE, 1'b0, 2, 1, 0};

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset:ready", {31'd0, req_ready}, 32'd0);
        chk("reset:strobes_resp", {29'd0, sig_mem_read, sig_mem_write, resp_valid}, 32'd0);
        chk("reset:resp_error", {31'd0, resp_error}, 32'd0);
        chk("reset:resp_rdata", resp_rdata, 32'd0);
        chk("reset:mem_address", mem_address, 32'd0);
        chk("reset:mem_write_data", mem_write_data, 32'd0);
        rst = 1'b0;
        #1;
        chk("reset:ready_after_release", {31'd0, req_ready}, 32'd1);

        // Directed vectors; the model runs alongside to keep its memory in step.
        for (int i = 0; i < 13; i++) begin
            model(vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a, vecs[i].wd, m_rd, m_er, m_lat, m_rc, m_wc);
            do_req(vecs[i].nm, vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a, vecs[i].wd,
                   vecs[i].e_rd, vecs[i].e_er, vecs[i].e_lat, vecs[i].e_rc, vecs[i].e_wc);
        end
        @(negedge clk);
        chk("mem_0x10_after_table", mem[4], 32'h1234_CAFE);

        // Reset during the read phase of a byte store must abandon the write.
        saved = mem[8];
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h21; req_wdata = 32'h77;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rmw_rst:read_strobe", {31'd0, sig_mem_read}, 32'd1);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rmw_rst:quiet_in_reset", {28'd0, sig_mem_read, sig_mem_write, resp_valid, req_ready}, 32'd0);
        end
        rst = 1'b0;
        #1;
        chk("rmw_rst:ready_after_release", {31'd0, req_ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rmw_rst:quiet_after", {29'd0, sig_mem_read, sig_mem_write, resp_valid}, 32'd0);
        end
        chk("rmw_rst:mem_unchanged", mem[8], saved);

        // Randomized requests against the behavioural model.
        for (int i = 0; i < 80; i++) begin
            bit        w;
            bit [1:0]  sz;
            bit        u;
            bit [31:0] a;
            bit [31:0] wd;
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            u  = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, 255));
            wd = $urandom;
            model(w, sz, u, a, wd, m_rd, m_er, m_lat, m_rc, m_wc);
            do_req("rand", w, sz, u, a, wd, m_rd, m_er, m_lat, m_rc, m_wc);
        end
        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            chk("final_mem_word", mem[i], ref_mem[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
